// File: rtl/branch_predictor.sv
// Bimodal 2-bit branch predictor with F->D->E record pipeline and resolution counters.
// Optional gshare indexing (PC XOR global history) is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned GHR_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_F,
  input  logic        branch_F,
  input  logic        stall_F,
  input  logic        stall_D,
  input  logic        stall_E,
  input  logic        flush_D,
  input  logic        flush_E,
  input  logic        branch_E,
  input  logic        actual_take_E,
  output logic        pred_take_F,
  output logic        pre_right,
  output logic        mispredict_E,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;

  logic [1:0]         pht [ENTRIES];
  logic [INDEX_W-1:0] idx_F, idx_D, idx_E;
  logic               valid_D, pred_D;
  logic               valid_E, pred_E;
  logic               update;

  logic unused_pc;
  assign unused_pc = ^{pc_F[31:INDEX_W+2], pc_F[1:0]};

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0]   ghr;
  logic [INDEX_W-1:0] ghr_ext;

  always_comb begin
    ghr_ext            = '0;
    ghr_ext[GHR_W-1:0] = ghr;
  end

  assign idx_F = pc_F[INDEX_W+1:2] ^ ghr_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (update) begin
      ghr <= {ghr[GHR_W-2:0], actual_take_E};
    end
  end
`else
  assign idx_F = pc_F[INDEX_W+1:2];
`endif

  assign pred_take_F  = ~rst & branch_F & pht[idx_F][1];
  assign pre_right    = rst | ~branch_E | (pred_E == actual_take_E);
  assign mispredict_E = branch_E & ~pre_right;
  assign update       = branch_E & valid_E & ~stall_E;

  // A stalled F with a moving D hands D a bubble so the branch is not counted twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_D <= 1'b0;
      pred_D  <= 1'b0;
      idx_D   <= '0;
      valid_E <= 1'b0;
      pred_E  <= 1'b0;
      idx_E   <= '0;
    end else begin
      if (flush_D) begin
        valid_D <= 1'b0;
        pred_D  <= 1'b0;
        idx_D   <= '0;
      end else if (!stall_D) begin
        valid_D <= branch_F & ~stall_F;
        pred_D  <= pred_take_F;
        idx_D   <= idx_F;
      end
      if (flush_E) begin
        valid_E <= 1'b0;
        pred_E  <= 1'b0;
        idx_E   <= '0;
      end else if (!stall_E) begin
        valid_E <= valid_D;
        pred_E  <= pred_D;
        idx_E   <= idx_D;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (update) begin
      if (actual_take_E && pht[idx_E] != 2'b11) begin
        pht[idx_E] <= pht[idx_E] + 2'd1;
      end else if (!actual_take_E && pht[idx_E] != 2'b00) begin
        pht[idx_E] <= pht[idx_E] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (update) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (mispredict_E) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build; gshare sequence when BP_GSHARE_EN is defined).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_F;
  logic        branch_F, stall_F, stall_D, stall_E, flush_D, flush_E;
  logic        branch_E, actual_take_E;
  logic        pred_take_F, pre_right, mispredict_E;
  logic [31:0] branch_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  logic p_f, m_e, r_e;

  branch_predictor #(.INDEX_W(6), .GHR_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_F         (pc_F),
    .branch_F     (branch_F),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .stall_E      (stall_E),
    .flush_D      (flush_D),
    .flush_E      (flush_E),
    .branch_E     (branch_E),
    .actual_take_E(actual_take_E),
    .pred_take_F  (pred_take_F),
    .pre_right    (pre_right),
    .mispredict_E (mispredict_E),
    .branch_cnt   (branch_cnt),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch one branch, let it pass D as a lone record, resolve it in E.
  task automatic run_branch(input logic [31:0] pc, input logic taken,
                            output logic pred_f, output logic mis_e, output logic right_e);
    pc_F = pc;
    branch_F = 1'b1;
    #1;
    pred_f = pred_take_F;
    tick();
    branch_F = 1'b0;
    tick();
    branch_E = 1'b1;
    actual_take_E = taken;
    #1;
    mis_e   = mispredict_E;
    right_e = pre_right;
    tick();
    branch_E = 1'b0;
    actual_take_E = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    pc_F = 32'h3010;
    branch_F = 1'b1;
    {stall_F, stall_D, stall_E, flush_D, flush_E} = '0;
    branch_E = 1'b1;
    actual_take_E = 1'b1;
    #2;
    check("rst_pred_take_F", {31'd0, pred_take_F}, 32'd0);
    check("rst_pre_right", {31'd0, pre_right}, 32'd1);
    check("rst_branch_cnt", branch_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    branch_F = 1'b0;
    branch_E = 1'b0;
    actual_take_E = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

`ifdef BP_GSHARE_EN
    run_branch(32'h3000, 1'b1, p_f, m_e, r_e);
    run_branch(32'h3000, 1'b1, p_f, m_e, r_e);
    check("gs_ghr", {26'd0, dut.ghr}, 32'd3);
    pc_F = 32'h3010;
    branch_F = 1'b1;
    #1;
    check("gs_idx_F", {26'd0, dut.idx_F}, 32'd7);
    check("gs_pred_idx7", {31'd0, pred_take_F}, 32'd0);
    tick();
    branch_F = 1'b0;
    tick();
    pc_F = 32'h3010;
    branch_F = 1'b1;
    branch_E = 1'b1;
    actual_take_E = 1'b1;
    #1;
    check("gs_same_idx_old", {31'd0, pred_take_F}, 32'd0);
    tick();
    branch_F = 1'b0;
    branch_E = 1'b0;
    check("gs_pht7_after", {30'd0, dut.pht[7]}, 32'h2);
`else
    check("pht4_reset", {30'd0, dut.pht[4]}, 32'h1);
    pc_F = 32'h3010;
    branch_F = 1'b1;
    #1;
    check("first_fetch_pred", {31'd0, pred_take_F}, 32'd0);
    branch_F = 1'b0;
    tick();

    run_branch(32'h3010, 1'b1, p_f, m_e, r_e);
    check("t1_pred", {31'd0, p_f}, 32'd0);
    check("t1_mispredict", {31'd0, m_e}, 32'd1);
    check("t1_pht4", {30'd0, dut.pht[4]}, 32'h2);
    run_branch(32'h3010, 1'b1, p_f, m_e, r_e);
    check("t2_pred", {31'd0, p_f}, 32'd1);
    check("t2_mispredict", {31'd0, m_e}, 32'd0);
    check("t2_pht4", {30'd0, dut.pht[4]}, 32'h3);
    check("t2_branch_cnt", branch_cnt, 32'd2);
    check("t2_miss_cnt", miss_cnt, 32'd1);
    pc_F = 32'h3010;
    branch_F = 1'b1;
    #1;
    check("t2_next_fetch", {31'd0, pred_take_F}, 32'd1);
    branch_F = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_branch(32'h3010, 1'b1, p_f, m_e, r_e);
      check("sat_hi_pht4", {30'd0, dut.pht[4]}, 32'h3);
    end
    run_branch(32'h3010, 1'b0, p_f, m_e, r_e);
    check("nt_mispredict", {31'd0, m_e}, 32'd1);
    check("nt_pre_right", {31'd0, r_e}, 32'd0);
    check("nt_pht4", {30'd0, dut.pht[4]}, 32'h2);
    check("nt_branch_cnt", branch_cnt, 32'd6);
    check("nt_miss_cnt", miss_cnt, 32'd2);

    // Same-index read during write returns the pre-update counter (10 -> predict taken).
    pc_F = 32'h3010;
    branch_F = 1'b1;
    tick();
    branch_F = 1'b0;
    tick();
    branch_F = 1'b1;
    branch_E = 1'b1;
    actual_take_E = 1'b0;
    #1;
    check("same_idx_old", {31'd0, pred_take_F}, 32'd1);
    tick();
    branch_F = 1'b0;
    branch_E = 1'b0;
    check("same_idx_pht4", {30'd0, dut.pht[4]}, 32'h1);
    check("same_idx_cnt", branch_cnt, 32'd7);
    tick();
    tick();

    pc_F = 32'h3014;
    branch_F = 1'b1;
    tick();
    branch_F = 1'b0;
    flush_E = 1'b1;
    tick();
    flush_E = 1'b0;
    branch_E = 1'b1;
    actual_take_E = 1'b1;
    tick();
    branch_E = 1'b0;
    actual_take_E = 1'b0;
    check("flushE_pht5", {30'd0, dut.pht[5]}, 32'h1);
    check("flushE_cnt", branch_cnt, 32'd7);

    pc_F = 32'h3018;
    branch_F = 1'b1;
    tick();
    branch_F = 1'b0;
    tick();
    branch_E = 1'b1;
    actual_take_E = 1'b1;
    stall_E = 1'b1;
    stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stallE_pht6_hold", {30'd0, dut.pht[6]}, 32'h1);
      check("stallE_cnt_hold", branch_cnt, 32'd7);
    end
    stall_E = 1'b0;
    stall_D = 1'b0;
    tick();
    branch_E = 1'b0;
    actual_take_E = 1'b0;
    check("stallE_pht6_once", {30'd0, dut.pht[6]}, 32'h2);
    check("stallE_cnt_once", branch_cnt, 32'd8);
    tick();
    check("stallE_pht6_final", {30'd0, dut.pht[6]}, 32'h2);

    pc_F = 32'h3014;
    branch_F = 1'b1;
    tick();
    branch_F = 1'b0;
    tick();
    branch_E = 1'b1;
    actual_take_E = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pre_right", {31'd0, pre_right}, 32'd1);
    tick();
    branch_E = 1'b0;
    actual_take_E = 1'b0;
    rst = 1'b0;
    tick();
    check("midrst_pht4", {30'd0, dut.pht[4]}, 32'h1);
    check("midrst_pht6", {30'd0, dut.pht[6]}, 32'h1);
    check("midrst_cnt", branch_cnt, 32'd0);
    check("midrst_valid_E", {31'd0, dut.valid_E}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, meaning the pattern table holds 2^INDEX_W two-bit counters.
REQ-002 SHALL have parameter GHR_W, default 6 (GHR_W <= INDEX_W), meaning the global history width used only under BP_GSHARE_EN.
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-005 SHALL have port pc_F, input, 32, the fetch-stage PC.
REQ-006 SHALL have port branch_F, input, 1, meaning a conditional branch is in F.
REQ-007 SHALL have ports stall_F, stall_D, stall_E, input, 1 each, meaning the corresponding stage holds.
REQ-008 SHALL have ports flush_D, flush_E, input, 1 each, meaning the corresponding stage is bubbled.
REQ-009 SHALL have port branch_E, input, 1, meaning a conditional branch is in E.
REQ-010 SHALL have port actual_take_E, input, 1, the resolved branch direction.
REQ-011 SHALL have port pred_take_F, output, 1, the taken prediction for F.
REQ-012 SHALL have port pre_right, output, 1, meaning the E prediction matches the outcome.
REQ-013 SHALL have port mispredict_E, output, 1, equal to branch_E & ~pre_right.
REQ-014 SHALL have ports branch_cnt and miss_cnt, output, 32 each, the resolved-branch and mispredict counters.

Function
REQ-015 SHALL form idx_F = pc_F[INDEX_W+1:2] when BP_GSHARE_EN is undefined.
REQ-016 SHALL drive pred_take_F = branch_F & PHT[idx_F][1], combinationally with no registered latency.
REQ-017 SHALL carry {valid, pred, idx} from F to D to E in pipeline registers; each register holds while its stage stalls.
REQ-018 SHALL load a zero (invalid) record into the D or E register when flush_D or flush_E is asserted; flush takes priority over stall.
REQ-019 SHALL compute pre_right = ~branch_E | (pred_E == actual_take_E), combinationally.
REQ-020 SHALL update PHT[idx_E] at the clock edge when branch_E & valid_E & ~stall_E: increment if taken, decrement if not taken.
REQ-021 SHALL saturate PHT counters, so that 2'b11 stays at 11 when taken and 2'b00 stays at 00 when not taken.
REQ-022 SHALL encode counters as 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
REQ-023 SHALL return the pre-update value when an F read and an E write hit the same index in the same cycle; there is no bypass.
REQ-024 SHALL increment branch_cnt on every counted update and miss_cnt on counted updates with mispredict_E; both wrap modulo 2^32.
REQ-025 SHALL use, for the update, the index captured at F, not an index recomputed from pc_E.

Reset
REQ-026 SHALL, on rst, set all PHT counters to 01 and all pipeline records to invalid, and clear both counters and the GHR.
REQ-027 SHALL force pred_take_F = 0 and pre_right = 1 while rst is asserted; a reset mid-branch discards the pending update.

Configuration
REQ-028 SHALL, with macro BP_GSHARE_EN defined, form idx_F = pc_F[INDEX_W+1:2] XOR zero-extended GHR and shift actual_take_E into GHR[0] on each counted update.
REQ-029 SHALL, without BP_GSHARE_EN, contain no GHR register and index the table by PC only.

Verification
REQ-030 SHALL cover: reset, then branch_F at pc_F = 0x3010 -> pred_take_F = 0; PHT[4] = 01.
REQ-031 SHALL cover: two resolved taken branches at 0x3010 -> PHT[4] goes 01 -> 10 -> 11; the next fetch gives pred_take_F = 1; branch_cnt = 2, miss_cnt = 1.
REQ-032 SHALL cover: three taken resolutions at a counter already at 11 -> it stays at 11; a not-taken resolution gives 10, mispredict_E = 1, pre_right = 0.
REQ-033 SHALL cover: branch in D with flush_E asserted -> the E record is invalid, no PHT update occurs, and branch_cnt is unchanged.
REQ-034 SHALL cover: stall_E held for 3 cycles with branch_E -> exactly one update, after stall_E deasserts.
REQ-035 SHALL cover, with BP_GSHARE_EN: GHR = 6'b000011 and pc_F = 0x3010 -> idx_F = 7; same-index read/write in one cycle -> the read returns the old value.
